// File: rtl/y86_pipe_alu_cc.sv
// y86_pipe_alu_cc: two-stage execute-stage ALU with valid/ready handshakes,
// Y86 condition-code register, jXX/cmovXX condition evaluator and flush.
module y86_pipe_alu_cc #(
  parameter int          WIDTH    = 64,
  parameter logic [2:0]  CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_zf,
  output logic             out_sf,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  input  logic [2:0]       cond_fn,
  output logic             cond
);

  // stage 1: latched operands
  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_fn_q, s1_fn_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s1_set_cc_q, s1_set_cc_d;
  // stage 2: computed result and flags
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_ovf_q, s2_ovf_d, s2_zf_q, s2_zf_d, s2_sf_q, s2_sf_d;
  logic             s2_set_cc_q, s2_set_cc_d;
  // architectural {ZF,SF,OF}
  logic [2:0]       cc_q, cc_d;

  logic             s2_load, s1_adv, in_xfer, out_xfer;
  logic [WIDTH-1:0] alu_r;
  logic             alu_ovf;

  // handshake: s2 refills when empty or draining; s1 drains into s2
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_load;
    in_ready = !flush && (!s1_valid_q || s1_adv);
    in_xfer  = in_valid && in_ready;
    out_xfer = s2_valid_q && out_ready;
  end

  // ALU on stage-1 operands, modulo 2^WIDTH, signed overflow from sign bits
  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    unique case (s1_fn_q)
      2'b00: begin
        alu_r   = s1_a_q + s1_b_q;
        alu_ovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                  (alu_r[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      2'b01: begin
        alu_r   = s1_a_q - s1_b_q;
        alu_ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                  (alu_r[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      2'b10:   alu_r = s1_a_q & s1_b_q;
      default: alu_r = s1_a_q ^ s1_b_q;
    endcase
  end

  // next-state for both stages and the CC register; flush kills everything
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fn_d     = s1_fn_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_set_cc_d = s1_set_cc_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_ovf_d    = s2_ovf_q;
    s2_zf_d     = s2_zf_q;
    s2_sf_d     = s2_sf_q;
    s2_set_cc_d = s2_set_cc_q;
    cc_d        = cc_q;

    if (in_xfer) begin
      s1_valid_d  = 1'b1;
      s1_fn_d     = in_fn;
      s1_a_d      = in_a;
      s1_b_d      = in_b;
      s1_set_cc_d = in_set_cc;
    end else if (s1_adv) begin
      s1_valid_d  = 1'b0;
    end

    if (s2_load) s2_valid_d = s1_valid_q;
    if (s1_adv) begin
      s2_result_d = alu_r;
      s2_ovf_d    = alu_ovf;
      s2_zf_d     = (alu_r == '0);
      s2_sf_d     = alu_r[WIDTH-1];
      s2_set_cc_d = s1_set_cc_q;
    end

    // a transfer coinciding with flush is treated as never having happened
    if (out_xfer && s2_set_cc_q && !flush) cc_d = {s2_zf_q, s2_sf_q, s2_ovf_q};

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // state registers; reset discards in-flight ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_fn_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_set_cc_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_ovf_q    <= 1'b0;
      s2_zf_q     <= 1'b0;
      s2_sf_q     <= 1'b0;
      s2_set_cc_q <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fn_q     <= s1_fn_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_set_cc_q <= s1_set_cc_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_zf_q     <= s2_zf_d;
      s2_sf_q     <= s2_sf_d;
      s2_set_cc_q <= s2_set_cc_d;
      cc_q        <= cc_d;
    end
  end

  // Y86 condition evaluator on the architectural CC
  always_comb begin
    unique case (cond_fn)
      3'd0:    cond = 1'b1;
      3'd1:    cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      3'd2:    cond = cc_q[1] ^ cc_q[0];
      3'd3:    cond = cc_q[2];
      3'd4:    cond = !cc_q[2];
      3'd5:    cond = !(cc_q[1] ^ cc_q[0]);
      3'd6:    cond = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
      default: cond = 1'b0;
    endcase
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_ovf    = s2_ovf_q;
  assign out_zf     = s2_zf_q;
  assign out_sf     = s2_sf_q;
  assign cc_zf      = cc_q[2];
  assign cc_sf      = cc_q[1];
  assign cc_of      = cc_q[0];

endmodule
